// File: rtl/as_gpio_in.sv
// as_gpio_in: memory-mapped GPIO input block.
// Pins are synchronised into clk_i and rising/falling edges are latched into
// sticky write-1-to-clear pending registers. Reads are registered one cycle.
// irq_o is raised while any enabled edge is pending.
module as_gpio_in #(
  parameter int nr_in       = 8,
  parameter int sync_stages = 2,
  parameter int addr_width  = 3,
  parameter int data_width  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [nr_in-1:0]      gpio_i,
  input  logic                  cs_i,
  input  logic                  we_i,
  input  logic [addr_width-1:0] addr_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  irq_o
);

  // Warm-up counter saturates at sync_stages+1; edges are only trusted after
  // that, so a pin already high out of reset is not seen as a rising edge.
  localparam int              CW        = 3;
  localparam logic [CW-1:0]   WARM_DONE = CW'(sync_stages + 1);

  localparam logic [addr_width-1:0] A_DATA = addr_width'(0);
  localparam logic [addr_width-1:0] A_RP   = addr_width'(1);
  localparam logic [addr_width-1:0] A_FP   = addr_width'(2);
  localparam logic [addr_width-1:0] A_RE   = addr_width'(3);
  localparam logic [addr_width-1:0] A_FE   = addr_width'(4);

  logic [sync_stages-1:0][nr_in-1:0] sync_q, sync_d;
  logic [nr_in-1:0]      prev_q, prev_d;
  logic [nr_in-1:0]      rpend_q, rpend_d, fpend_q, fpend_d;
  logic [nr_in-1:0]      ren_q, ren_d, fen_q, fen_d;
  logic [CW-1:0]         warm_q, warm_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  irq_q, irq_d;

  logic [nr_in-1:0] synced, rise, fall, wmask;
  logic             edge_en, rd_en, wr_en;

  // Upper write-data bits beyond nr_in have no register behind them.
  logic unused_wdata;
  assign unused_wdata = ^wdata_i;

  // Synchroniser shift chain; stage 0 samples the raw pins.
  always_comb begin
    sync_d = {sync_q[sync_stages-2:0], gpio_i};
  end

  // Edge detect, pending/enable register updates, read mux and irq.
  always_comb begin
    synced  = sync_q[sync_stages-1];
    edge_en = (warm_q == WARM_DONE);
    rise    = edge_en ? (synced & ~prev_q) : '0;
    fall    = edge_en ? (~synced & prev_q) : '0;
    rd_en   = cs_i & ~we_i;
    wr_en   = cs_i & we_i;
    wmask   = wdata_i[nr_in-1:0];

    warm_d  = edge_en ? warm_q : warm_q + CW'(1);
    prev_d  = synced;

    rpend_d = rpend_q;
    fpend_d = fpend_q;
    ren_d   = ren_q;
    fen_d   = fen_q;
    if (wr_en) begin
      case (addr_i)
        A_RP:    rpend_d = rpend_q & ~wmask;
        A_FP:    fpend_d = fpend_q & ~wmask;
        A_RE:    ren_d   = wmask;
        A_FE:    fen_d   = wmask;
        default: ;
      endcase
    end
    // A new edge overrides a same-cycle clear of that bit.
    rpend_d = rpend_d | rise;
    fpend_d = fpend_d | fall;

    // Reads see register values from before this cycle's update.
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (addr_i)
        A_DATA:  rdata_d[nr_in-1:0] = synced;
        A_RP:    rdata_d[nr_in-1:0] = rpend_q;
        A_FP:    rdata_d[nr_in-1:0] = fpend_q;
        A_RE:    rdata_d[nr_in-1:0] = ren_q;
        A_FE:    rdata_d[nr_in-1:0] = fen_q;
        default: ;
      endcase
    end
    rvalid_d = rd_en;
    irq_d    = (|(rpend_q & ren_q)) | (|(fpend_q & fen_q));
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q   <= '0;
      prev_q   <= '0;
      rpend_q  <= '0;
      fpend_q  <= '0;
      ren_q    <= '0;
      fen_q    <= '0;
      warm_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      rpend_q  <= rpend_d;
      fpend_q  <= fpend_d;
      ren_q    <= ren_d;
      fen_q    <= fen_d;
      warm_q   <= warm_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign irq_o    = irq_q;

endmodule
